// File: rtl/data_memory_arbiter.sv
// Shares one data memory port between the CPU and DMA requesters using an IDLE/ACCESS/RESPOND
// sequence. Define DATA_MEMORY_ARBITER_ROUND_ROBIN_EN for round-robin ties (default: CPU wins).
module data_memory_arbiter #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned MEM_DEPTH  = 256
) (
    input  logic                  i_clock,
    input  logic                  i_reset_n,
    input  logic                  i_cpu_req,
    input  logic                  i_cpu_we,
    input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
    input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
    output logic                  o_cpu_ack,
    output logic                  o_cpu_done,
    output logic [DATA_WIDTH-1:0] o_cpu_rdata,
    output logic                  o_cpu_err,
    input  logic                  i_dma_req,
    input  logic                  i_dma_we,
    input  logic [ADDR_WIDTH-1:0] i_dma_addr,
    input  logic [DATA_WIDTH-1:0] i_dma_wdata,
    output logic                  o_dma_ack,
    output logic                  o_dma_done,
    output logic [DATA_WIDTH-1:0] o_dma_rdata,
    output logic                  o_dma_err,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_wdata,
    output logic                  o_mem_write_en,
    output logic                  o_mem_read_en,
    input  logic [DATA_WIDTH-1:0] i_mem_rdata,
    output logic                  o_busy
);
    localparam int unsigned CMP_WIDTH = (ADDR_WIDTH > 32) ? ADDR_WIDTH : 32;

    typedef enum logic [1:0] {StIdle, StAccess, StRespond} state_e;

    state_e                r_state, w_state_next;
    logic                  r_owner, r_we, r_oor;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_cpu_ack, r_dma_ack, r_cpu_done, r_dma_done;
    logic                  r_cpu_err, r_dma_err, r_mem_we, r_mem_re;
    logic [DATA_WIDTH-1:0] r_cpu_rdata, r_dma_rdata;

    logic                  w_any_req, w_grant_dma, w_sel_we, w_sel_oor;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata, w_resp_data;
    logic                  w_take, w_cpu_ack, w_dma_ack, w_cpu_done, w_dma_done;
    logic                  w_mem_we, w_mem_re;

    assign w_any_req = i_cpu_req | i_dma_req;

`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
    logic r_last_grant;  // 1 = DMA was served last
    assign w_grant_dma = i_dma_req & (~i_cpu_req | ~r_last_grant);
`else
    assign w_grant_dma = i_dma_req & ~i_cpu_req;
`endif

    assign w_sel_we    = w_grant_dma ? i_dma_we    : i_cpu_we;
    assign w_sel_addr  = w_grant_dma ? i_dma_addr  : i_cpu_addr;
    assign w_sel_wdata = w_grant_dma ? i_dma_wdata : i_cpu_wdata;
    // Full-width compare: no truncation of high address bits
    assign w_sel_oor   = CMP_WIDTH'(w_sel_addr) >= CMP_WIDTH'(MEM_DEPTH);
    assign w_resp_data = (r_we | r_oor) ? '0 : i_mem_rdata;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_take       = 1'b0;
        w_cpu_ack    = 1'b0;
        w_dma_ack    = 1'b0;
        w_cpu_done   = 1'b0;
        w_dma_done   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;
        unique case (r_state)
            StIdle: begin
                if (w_any_req) begin
                    w_state_next = StAccess;
                    w_take       = 1'b1;
                    w_cpu_ack    = ~w_grant_dma;
                    w_dma_ack    = w_grant_dma;
                    w_mem_we     = w_sel_we & ~w_sel_oor;
                    w_mem_re     = ~w_sel_we & ~w_sel_oor;
                end
            end
            StAccess: w_state_next = StRespond;
            StRespond: begin
                w_state_next = StIdle;
                w_cpu_done   = ~r_owner;
                w_dma_done   = r_owner;
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_owner     <= 1'b0;
            r_we        <= 1'b0;
            r_oor       <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_cpu_ack   <= 1'b0;
            r_dma_ack   <= 1'b0;
            r_cpu_done  <= 1'b0;
            r_dma_done  <= 1'b0;
            r_cpu_err   <= 1'b0;
            r_dma_err   <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_re    <= 1'b0;
`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            r_cpu_ack  <= w_cpu_ack;
            r_dma_ack  <= w_dma_ack;
            r_cpu_done <= w_cpu_done;
            r_dma_done <= w_dma_done;
            r_mem_we   <= w_mem_we;
            r_mem_re   <= w_mem_re;
            if (w_take) begin
                r_owner <= w_grant_dma;
                r_we    <= w_sel_we;
                r_oor   <= w_sel_oor;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
            end
            if (w_cpu_done) begin
                r_cpu_rdata <= w_resp_data;
                r_cpu_err   <= r_oor;
            end
            if (w_dma_done) begin
                r_dma_rdata <= w_resp_data;
                r_dma_err   <= r_oor;
            end
`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
            if (r_state == StRespond) begin
                r_last_grant <= r_owner;
            end
`endif
        end
    end

    assign o_cpu_ack      = r_cpu_ack;
    assign o_dma_ack      = r_dma_ack;
    assign o_cpu_done     = r_cpu_done;
    assign o_dma_done     = r_dma_done;
    assign o_cpu_rdata    = r_cpu_rdata;
    assign o_dma_rdata    = r_dma_rdata;
    assign o_cpu_err      = r_cpu_err;
    assign o_dma_err      = r_dma_err;
    assign o_mem_addr     = r_addr;
    assign o_mem_wdata    = r_wdata;
    assign o_mem_write_en = r_mem_we;
    assign o_mem_read_en  = r_mem_re;
    assign o_busy         = (r_state != StIdle);

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench for data_memory_arbiter: vector table, reset/tie sequences and random
// single-port traffic checked against a plain array model of the data memory.
module tb_data_memory_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_req, cpu_we, dma_req, dma_we;
    logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
    logic        cpu_ack, cpu_done, cpu_err, dma_ack, dma_done, dma_err;
    logic [15:0] cpu_rdata, dma_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_write_en, mem_read_en, busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] mem_arr [256];
    logic [15:0] ref_mem [256];

    typedef struct {
        bit          dma;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
        bit          err;
    } vec_t;

    vec_t vecs [12];

    data_memory_arbiter dut (
        .i_clock        (clk),
        .i_reset_n      (reset_n),
        .i_cpu_req      (cpu_req),
        .i_cpu_we       (cpu_we),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_wdata    (cpu_wdata),
        .o_cpu_ack      (cpu_ack),
        .o_cpu_done     (cpu_done),
        .o_cpu_rdata    (cpu_rdata),
        .o_cpu_err      (cpu_err),
        .i_dma_req      (dma_req),
        .i_dma_we       (dma_we),
        .i_dma_addr     (dma_addr),
        .i_dma_wdata    (dma_wdata),
        .o_dma_ack      (dma_ack),
        .o_dma_done     (dma_done),
        .o_dma_rdata    (dma_rdata),
        .o_dma_err      (dma_err),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_write_en (mem_write_en),
        .o_mem_read_en  (mem_read_en),
        .i_mem_rdata    (mem_rdata),
        .o_busy         (busy)
    );

    always #5 clk = ~clk;

    // Synchronous-read data memory seen by the DUT
    always @(posedge clk) begin
        if (mem_write_en) mem_arr[mem_addr[7:0]] <= mem_wdata;
        if (mem_read_en)  mem_rdata <= mem_arr[mem_addr[7:0]];
    end

    task automatic check1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic check_all_zero(input string nm);
        check1({nm, " cpu_ack"}, cpu_ack, 1'b0);
        check1({nm, " dma_ack"}, dma_ack, 1'b0);
        check1({nm, " cpu_done"}, cpu_done, 1'b0);
        check1({nm, " dma_done"}, dma_done, 1'b0);
        check16({nm, " cpu_rdata"}, cpu_rdata, 16'h0);
        check16({nm, " dma_rdata"}, dma_rdata, 16'h0);
        check1({nm, " cpu_err"}, cpu_err, 1'b0);
        check1({nm, " dma_err"}, dma_err, 1'b0);
        check16({nm, " mem_addr"}, mem_addr, 16'h0);
        check16({nm, " mem_wdata"}, mem_wdata, 16'h0);
        check1({nm, " mem_write_en"}, mem_write_en, 1'b0);
        check1({nm, " mem_read_en"}, mem_read_en, 1'b0);
        check1({nm, " busy"}, busy, 1'b0);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0;
        cpu_req = 1'b0;
        dma_req = 1'b0;
        #1 check_all_zero("reset");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
    endtask

    // Behavioural expectation for one isolated access
    task automatic model_txn(input bit we, input logic [15:0] addr, input logic [15:0] wdata,
                             output logic [15:0] rdata, output bit err);
        err   = (int'(addr) >= 256);
        rdata = 16'h0;
        if (!err) begin
            if (we) ref_mem[int'(addr)] = wdata;
            else    rdata = ref_mem[int'(addr)];
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the done cycle
    task automatic do_txn(input string nm, input bit dma, input bit we, input logic [15:0] addr,
                          input logic [15:0] wdata, input logic [15:0] rdata_exp,
                          input bit err_exp);
        int  waits;
        bit  seen;
        bit  in_rng;
        in_rng = (int'(addr) < 256);
        if (dma) begin
            dma_req = 1'b1; dma_we = we; dma_addr = addr; dma_wdata = wdata;
        end else begin
            cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
        end
        waits = 0;
        seen  = 1'b0;
        while (!seen && waits < 8) begin
            @(negedge clk);
            waits++;
            seen = dma ? dma_ack : cpu_ack;
        end
        cpu_req = 1'b0;
        dma_req = 1'b0;
        check1({nm, " ack seen"}, seen, 1'b1);
        if (!seen) return;
        check16({nm, " ack latency"}, 16'(waits), 16'd1);
        check1({nm, " other ack"}, dma ? cpu_ack : dma_ack, 1'b0);
        check16({nm, " mem_addr"}, mem_addr, addr);
        if (we) check16({nm, " mem_wdata"}, mem_wdata, wdata);
        check1({nm, " write_en"}, mem_write_en, we & in_rng);
        check1({nm, " read_en"}, mem_read_en, ~we & in_rng);
        @(negedge clk);
        check1({nm, " respond enables"}, mem_write_en | mem_read_en, 1'b0);
        check1({nm, " respond busy"}, busy, 1'b1);
        check1({nm, " early done"}, cpu_done | dma_done, 1'b0);
        @(negedge clk);
        check1({nm, " done"}, dma ? dma_done : cpu_done, 1'b1);
        check1({nm, " other done"}, dma ? cpu_done : dma_done, 1'b0);
        check16({nm, " rdata"}, dma ? dma_rdata : cpu_rdata, rdata_exp);
        check1({nm, " err"}, dma ? dma_err : cpu_err, err_exp);
        check1({nm, " idle busy"}, busy, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] r_exp;
        bit          e_exp;
        bit          any_done;
        bit          exp_dma [4];
        int          prev_owner;

        for (int i = 0; i < 256; i++) begin
            mem_arr[i] = 16'h0;
            ref_mem[i] = 16'h0;
        end
        reset_n = 1'b0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0; dma_wdata = 16'h0;
        repeat (2) @(negedge clk);
        check_all_zero("reset hold");
        reset_n = 1'b1;
        @(negedge clk);
        check_all_zero("after reset");

        // Reset in the middle of ACCESS drops the write and never produces done
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 16'd1; cpu_wdata = 16'hAAAA;
        @(negedge clk);
        check1("midrst ack", cpu_ack, 1'b1);
        check1("midrst write_en", mem_write_en, 1'b1);
        #2 reset_n = 1'b0;
        #1 check_all_zero("midrst async");
        cpu_req = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        any_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            any_done |= cpu_done | dma_done;
        end
        check1("midrst no done", any_done, 1'b0);

        vecs[0]  = '{0, 1, 16'd1,     16'h0010, 16'h0000, 0};
        vecs[1]  = '{0, 0, 16'd1,     16'h0000, 16'h0010, 0};
        vecs[2]  = '{1, 0, 16'd256,   16'h0000, 16'h0000, 1};
        vecs[3]  = '{1, 1, 16'd255,   16'h1234, 16'h0000, 0};
        vecs[4]  = '{1, 0, 16'd255,   16'h0000, 16'h1234, 0};
        vecs[5]  = '{1, 1, 16'd7,     16'hBEEF, 16'h0000, 0};
        vecs[6]  = '{0, 0, 16'd7,     16'h0000, 16'hBEEF, 0};
        vecs[7]  = '{0, 1, 16'hFFFF,  16'h5555, 16'h0000, 1};
        vecs[8]  = '{0, 0, 16'hFFFF,  16'h0000, 16'h0000, 1};
        vecs[9]  = '{1, 0, 16'd1,     16'h0000, 16'h0010, 0};
        vecs[10] = '{0, 1, 16'h0100,  16'h7777, 16'h0000, 1};
        vecs[11] = '{0, 0, 16'd0,     16'h0000, 16'h0000, 0};
        for (int i = 0; i < 12; i++) begin
            model_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, r_exp, e_exp);
            do_txn($sformatf("vec%0d", i), vecs[i].dma, vecs[i].we, vecs[i].addr,
                   vecs[i].wdata, vecs[i].rdata, vecs[i].err);
        end

        for (int i = 0; i < 40; i++) begin
            bit          p, w;
            logic [15:0] a, d;
            p = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            a = ($urandom_range(0, 4) == 0) ? 16'($urandom_range(250, 270))
                                            : 16'($urandom_range(0, 15));
            d = 16'($urandom);
            model_txn(w, a, d, r_exp, e_exp);
            do_txn($sformatf("rand%0d", i), p, w, a, d, r_exp, e_exp);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        // Both requesters held high from reset
`ifdef DATA_MEMORY_ARBITER_ROUND_ROBIN_EN
        exp_dma = '{0, 1, 0, 1};
`else
        exp_dma = '{0, 0, 0, 1};
`endif
        apply_reset();
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'd2;
        dma_req = 1'b1; dma_we = 1'b0; dma_addr = 16'd3;
        prev_owner = -1;
        for (int k = 0; k < 4; k++) begin
            int waits;
            bit seen;
            waits = 0;
            seen  = 1'b0;
            while (!seen && waits < 6) begin
                @(negedge clk);
                waits++;
                if (cpu_done | dma_done) begin
                    check1("tie cpu_done owner", cpu_done, prev_owner == 0);
                    check1("tie dma_done owner", dma_done, prev_owner == 1);
                end
                seen = cpu_ack | dma_ack;
            end
            check1("tie grant seen", seen, 1'b1);
            if (!seen) break;
            check16("tie ack spacing", 16'(waits), (k == 0) ? 16'd1 : 16'd3);
            check1("tie single ack", cpu_ack & dma_ack, 1'b0);
            check1($sformatf("tie grant%0d is dma", k), dma_ack, exp_dma[k]);
            prev_owner = dma_ack ? 1 : 0;
            if (k == 2) cpu_req = 1'b0;
            if (k == 3) dma_req = 1'b0;
        end
        repeat (2) @(negedge clk);
        check1("tie last dma_done", dma_done, prev_owner == 1);
        check1("tie last cpu_done", cpu_done, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
